sw_max_score_tracker: RTL and testbench

Downstream consumer of the Smith-Waterman systolic PE array. It watches every PE's score and activity output each cycle and tracks the maximum local-alignment score over the whole run, with the PE index and cycle where that score occurred. After the upstream sequencer signals that the reference stream has ended, the block drains the array wavefront and returns the result through a valid/ready handshake.

---
 rtl/sw_max_score_tracker.sv | 134 +++++++++++++
 tb/tb_sw_max_score_tracker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_max_score_tracker.sv
// Tracks the best local-alignment score across all PEs of a Smith-Waterman array for one run,
// then drains the array wavefront and hands {score, pe, cycle} out over a valid/ready handshake.
module sw_max_score_tracker #(
    parameter int N_PE    = 8,
    parameter int SCORE_W = 10,
    parameter int POS_W   = 16,
    localparam int PE_W   = $clog2(N_PE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N_PE*SCORE_W-1:0]   v_all,
    input  logic [N_PE-1:0]           act_all,
    input  logic                      done_in,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [SCORE_W-1:0]        best_score,
    output logic [PE_W-1:0]           best_pe,
    output logic [POS_W-1:0]          best_cycle,
    output logic                      busy,
    output logic [1:0]                fsm_state
);

    // Handshake: the result is transferred on any edge where res_valid && res_ready;
    // while res_valid is high and res_ready low, best_* and res_valid are held.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(N_PE + 3) + 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   drain_cnt;
    logic [POS_W-1:0]   cyc;
    logic               sampling;

    logic               s1_valid;
    logic [SCORE_W-1:0] s1_score;
    logic [PE_W-1:0]    s1_pe;
    logic [POS_W-1:0]   s1_cyc;

    logic [SCORE_W-1:0] lane_val;
    logic [SCORE_W-1:0] lane_max;
    logic [PE_W-1:0]    lane_pe;

    assign sampling  = (state == RUN) || (state == DRAIN);
    assign res_valid = (state == REPORT);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)                state_nxt = RUN;
            RUN:     if (done_in)              state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == '0)      state_nxt = REPORT;
            REPORT:  if (res_ready)            state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // Negative scores fail the sign test and so behave as 0; strict '>' keeps the lowest index on ties.
    always_comb begin
        lane_val = '0;
        lane_max = '0;
        lane_pe  = '0;
        for (int i = 0; i < N_PE; i++) begin
            lane_val = v_all[i*SCORE_W +: SCORE_W];
            if (act_all[i] && !lane_val[SCORE_W-1] && (lane_val > lane_max)) begin
                lane_max = lane_val;
                lane_pe  = PE_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            cyc        <= '0;
            s1_valid   <= 1'b0;
            s1_score   <= '0;
            s1_pe      <= '0;
            s1_cyc     <= '0;
            best_score <= '0;
            best_pe    <= '0;
            best_cycle <= '0;
        end else begin
            state <= state_nxt;

            // The counter runs down through zero so the stage-2 update of the last
            // included sample has landed before REPORT is entered.
            if (state == RUN && done_in) begin
                drain_cnt <= CNT_W'(N_PE + 2);
            end else if (state == DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end

            if (state == IDLE) begin
                s1_valid <= 1'b0;
                if (start) begin
                    cyc        <= '0;
                    s1_score   <= '0;
                    s1_pe      <= '0;
                    s1_cyc     <= '0;
                    best_score <= '0;
                    best_pe    <= '0;
                    best_cycle <= '0;
                end
            end else if (sampling) begin
                s1_valid <= (lane_max != '0);
                s1_score <= lane_max;
                s1_pe    <= lane_pe;
                s1_cyc   <= cyc;
                if (cyc != '1) begin
                    cyc <= cyc + 1'b1;
                end
                // Strict compare: an equal score seen later never displaces the earlier one.
                if (s1_valid && (s1_score > best_score)) begin
                    best_score <= s1_score;
                    best_pe    <= s1_pe;
                    best_cycle <= s1_cyc;
                end
            end else begin
                s1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sw_max_score_tracker.sv
// Directed and randomized runs of sw_max_score_tracker checked against a whole-run max-scan model.
module tb_sw_max_score_tracker;

    localparam int N  = 4;
    localparam int SW = 10;
    localparam int PW = 16;
    localparam int EW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N*SW-1:0] v_all;
    logic [N-1:0]    act_all;
    logic            done_in;
    logic            res_valid;
    logic            res_ready;
    logic [SW-1:0]   best_score;
    logic [EW-1:0]   best_pe;
    logic [PW-1:0]   best_cycle;
    logic            busy;
    logic [1:0]      fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [N*SW-1:0] stim_v[$];
    logic [N-1:0]    stim_a[$];

    sw_max_score_tracker #(.N_PE(N), .SCORE_W(SW), .POS_W(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .v_all(v_all), .act_all(act_all),
        .done_in(done_in), .res_valid(res_valid), .res_ready(res_ready),
        .best_score(best_score), .best_pe(best_pe), .best_cycle(best_cycle),
        .busy(busy), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_zero(input int n);
        repeat (n) begin
            stim_v.push_back('0);
            stim_a.push_back('0);
        end
    endtask

    task automatic set_lane(input int k, input int i, input int val, input bit act);
        logic [N*SW-1:0] tv;
        logic [N-1:0]    ta;
        tv = stim_v[k];
        ta = stim_a[k];
        tv[i*SW +: SW] = SW'(val);
        ta[i] = act;
        stim_v[k] = tv;
        stim_a[k] = ta;
    endtask

    // Reference: scan every recorded sample in tag order, lanes in index order, keep the first strict maximum.
    task automatic model(output int es, output int ep, output int ec);
        logic [SW-1:0] raw;
        int s;
        es = 0; ep = 0; ec = 0;
        foreach (stim_v[k]) begin
            for (int i = 0; i < N; i++) begin
                raw = stim_v[k][i*SW +: SW];
                s = $signed(raw);
                if (stim_a[k][i] && s > es) begin
                    es = s; ep = i; ec = k;
                end
            end
        end
    endtask

    task automatic run(input string name, input int done_tag, input bit done_with_start,
                       input int hold, input bit poke);
        int es, ep, ec, m;
        bit early;
        while (stim_v.size() < done_tag + N + 2) push_zero(1);
        model(es, ep, ec);

        start = 1'b1; done_in = done_with_start;
        tick();
        start = 1'b0; done_in = 1'b0;
        check({name, "_busy_run"}, 32'(busy), 32'd1);

        early = 1'b0;
        for (int k = 0; k < stim_v.size(); k++) begin
            v_all = stim_v[k]; act_all = stim_a[k]; done_in = (k == done_tag);
            tick();
            if (res_valid) early = 1'b1;
        end
        done_in = 1'b0; v_all = '0; act_all = '0;
        m = 0;
        while (!res_valid && m < 20) begin
            tick();
            m++;
        end
        check({name, "_early_valid"}, 32'(early), 32'd0);
        check({name, "_latency"}, 32'(stim_v.size() - 1 - done_tag + m), 32'(N + 3));
        check({name, "_score"}, 32'(best_score), 32'(es));
        check({name, "_pe"}, 32'(best_pe), 32'(ep));
        check({name, "_cycle"}, 32'(best_cycle), 32'(ec));

        res_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (poke && h == 1) begin start = 1'b1; done_in = 1'b1; end
            tick();
            start = 1'b0; done_in = 1'b0;
        end
        if (hold > 0) begin
            check({name, "_hold_valid"}, 32'(res_valid), 32'd1);
            check({name, "_hold_state"}, 32'(fsm_state), 32'd3);
            check({name, "_hold_score"}, 32'(best_score), 32'(es));
            check({name, "_hold_cycle"}, 32'(best_cycle), 32'(ec));
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({name, "_post_valid"}, 32'(res_valid), 32'd0);
        check({name, "_post_busy"}, 32'(busy), 32'd0);
        check({name, "_post_score"}, 32'(best_score), 32'(es));
        stim_v.delete();
        stim_a.delete();
    endtask

    initial begin
        logic [N*SW-1:0] tv;
        int dt;

        rst = 1'b1; start = 1'b0; v_all = '0; act_all = '0; done_in = 1'b0; res_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_score", 32'(best_score), 32'd0);
        check("rst_pe", 32'(best_pe), 32'd0);
        check("rst_cycle", 32'(best_cycle), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        rst = 1'b0;
        tick();

        push_zero(11); set_lane(5, 2, 37, 1'b1);
        run("peak", 10, 1'b0, 0, 1'b0);
        check("peak_const_score", 32'(best_score), 32'd37);
        check("peak_const_pe", 32'(best_pe), 32'd2);
        check("peak_const_cycle", 32'(best_cycle), 32'd5);

        push_zero(6); set_lane(3, 1, 20, 1'b1); set_lane(3, 3, 20, 1'b1);
        run("tie_same", 5, 1'b1, 0, 1'b0);
        check("tie_same_pe", 32'(best_pe), 32'd1);
        check("tie_same_cycle", 32'(best_cycle), 32'd3);

        push_zero(10);
        set_lane(3, 0, 20, 1'b1); set_lane(7, 2, 20, 1'b1); set_lane(8, 1, 19, 1'b1);
        run("tie_cross", 9, 1'b0, 0, 1'b0);
        check("tie_cross_score", 32'(best_score), 32'd20);
        check("tie_cross_pe", 32'(best_pe), 32'd0);
        check("tie_cross_cycle", 32'(best_cycle), 32'd3);

        push_zero(5);
        set_lane(2, 0, 99, 1'b0); set_lane(2, 1, -5, 1'b1); set_lane(2, 3, 5, 1'b1);
        run("mask", 4, 1'b0, 0, 1'b0);
        check("mask_score", 32'(best_score), 32'd5);
        check("mask_pe", 32'(best_pe), 32'd3);

        push_zero(5);
        set_lane(1, 0, -100, 1'b1); set_lane(2, 2, 300, 1'b0); set_lane(3, 1, -1, 1'b1);
        run("neg_only", 4, 1'b0, 0, 1'b0);
        check("neg_only_score", 32'(best_score), 32'd0);
        check("neg_only_cycle", 32'(best_cycle), 32'd0);

        push_zero(3 + N + 2); set_lane(3 + N + 1, 1, 44, 1'b1);
        run("drain_edge", 3, 1'b0, 0, 1'b0);
        check("drain_edge_score", 32'(best_score), 32'd44);
        check("drain_edge_cycle", 32'(best_cycle), 32'(3 + N + 1));

        push_zero(6); set_lane(2, 3, 60, 1'b1);
        run("backpressure", 5, 1'b0, 5, 1'b1);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tv = '0;
            if (k == 2) tv[SW-1:0] = SW'(50);
            v_all = tv; act_all = (k == 2) ? N'(1) : '0;
            tick();
        end
        v_all = '0; act_all = '0;
        check("midrun_seen", 32'(best_score), 32'd50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_rst_score", 32'(best_score), 32'd0);
        check("midrun_rst_cycle", 32'(best_cycle), 32'd0);
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_valid", 32'(res_valid), 32'd0);
        check("midrun_rst_state", 32'(fsm_state), 32'd0);
        tick();
        push_zero(8); set_lane(4, 1, 12, 1'b1);
        run("after_rst", 6, 1'b0, 0, 1'b0);
        check("after_rst_score", 32'(best_score), 32'd12);

        for (int r = 0; r < 8; r++) begin
            dt = $urandom_range(2, 30);
            for (int k = 0; k < dt + N + 2; k++) begin
                for (int i = 0; i < N; i++) tv[i*SW +: SW] = SW'($urandom_range(0, 1023));
                stim_v.push_back(tv);
                stim_a.push_back(N'($urandom_range(0, 15)));
            end
            run($sformatf("rand%0d", r), dt, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
